// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot or auto-reload mode,
// and a registered one-cycle terminal-count pulse.
//
// state | meaning
// IDLE  | holding q, not counting
// RUN   | counting down once per prescaled tick
module down_timer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  input  logic               start,
  input  logic               stop,
  input  logic               auto_reload,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               tc
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [WIDTH-1:0]   reload_reg, reload_nxt;
  logic [PRESC_W-1:0] presc_cnt, presc_nxt;
  logic               tc_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      presc_cnt  <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      reload_reg <= reload_nxt;
      presc_cnt  <= presc_nxt;
      tc         <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload_reg;
    presc_nxt  = presc_cnt;
    tc_nxt     = 1'b0;
    if (load) begin
      q_nxt      = load_value;
      reload_nxt = load_value;
      presc_nxt  = '0;
      if (state == RUN && load_value == '0)
        state_nxt = IDLE;
    end else if (stop) begin
      if (state == RUN) begin
        state_nxt = IDLE;
        presc_nxt = '0;
      end
    end else if (start && state == IDLE) begin
      if (q != '0) begin
        state_nxt = RUN;
        presc_nxt = '0;
      end
    end else if (state == RUN) begin
      // >= keeps a live shrink of prescale from stalling the prescaler
      if (presc_cnt >= prescale) begin
        presc_nxt = '0;
        if (q > WIDTH'(1)) begin
          q_nxt = q - WIDTH'(1);
        end else if (q == WIDTH'(1)) begin
          tc_nxt = 1'b1;
          if (auto_reload && reload_reg != '0) begin
            q_nxt = reload_reg;
          end else begin
            q_nxt     = '0;
            state_nxt = IDLE;
          end
        end
      end else begin
        presc_nxt = presc_cnt + PRESC_W'(1);
      end
    end
  end

  assign busy = (state == RUN);

endmodule
